// File: rtl/axi_func_pkg.sv
// Shared AXI helpers: burst encoding, response codes and the address,
// byte-lane and wrap-boundary arithmetic used by the write front-end.
package axi_func_pkg;

    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned STROBE_WIDTH   = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic [31:0] aligned_address(input logic [31:0] addr,
                                                    input logic [2:0]  size);
        return (addr >> size) << size;
    endfunction

    // Wrap regions are always a power of two, so the lower boundary is a mask.
    function automatic logic [31:0] wrap_boundary(input logic [31:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [7:0]  len);
        logic [31:0] wrap_bytes;
        wrap_bytes = (32'(len) + 32'd1) << size;
        return addr & ~(wrap_bytes - 32'd1);
    endfunction

    function automatic logic [31:0] lower_byte_lane(input logic [31:0] addr,
                                                    input int unsigned db_log2);
        return addr & ((32'd1 << db_log2) - 32'd1);
    endfunction

    function automatic logic [31:0] upper_byte_lane(input logic [31:0] addr,
                                                    input logic [2:0]  size,
                                                    input int unsigned db_log2,
                                                    input logic        first_beat);
        logic [31:0] db_base;
        db_base = addr & ~((32'd1 << db_log2) - 32'd1);
        if (first_beat) begin
            return aligned_address(addr, size) + (32'd1 << size) - 32'd1 - db_base;
        end
        return lower_byte_lane(addr, db_log2) + (32'd1 << size) - 32'd1;
    endfunction

endpackage

// File: rtl/axi_wr_lane_calc.sv
// Combinational per-beat address step and active byte-lane mask for one
// AXI write beat.
module axi_wr_lane_calc
    import axi_func_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0]   cur_addr,
    input  logic [2:0]              size,
    input  logic [7:0]              len,
    input  burst_e                  burst,
    input  logic                    first_beat,
    output logic [ADDR_WIDTH-1:0]   next_addr,
    output logic [DATA_WIDTH/8-1:0] lane_mask
);

    localparam int unsigned DB      = DATA_WIDTH / 8;
    localparam int unsigned DB_LOG2 = $clog2(DB);

    logic [31:0] addr_w;
    logic [31:0] incr_addr;
    logic [31:0] wrap_lo;
    logic [31:0] wrap_hi;
    logic [31:0] nxt;
    logic [31:0] lane_lo;
    logic [31:0] lane_hi;

    // Arithmetic is done at 32 bits so the wrap upper boundary and the INCR
    // carry out of the top address never overflow before truncation.
    always_comb begin
        addr_w    = 32'(cur_addr);
        incr_addr = aligned_address(addr_w, size) + (32'd1 << size);
        wrap_lo   = wrap_boundary(addr_w, size, len);
        wrap_hi   = wrap_lo + ((32'(len) + 32'd1) << size);

        case (burst)
            BURST_FIXED: nxt = addr_w;
            BURST_WRAP:  nxt = (incr_addr == wrap_hi) ? wrap_lo : incr_addr;
            default:     nxt = incr_addr;
        endcase
        next_addr = ADDR_WIDTH'(nxt);

        lane_lo = lower_byte_lane(addr_w, DB_LOG2);
        lane_hi = upper_byte_lane(addr_w, size, DB_LOG2, first_beat);
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        lane_mask = '0;
        for (int unsigned i = 0; i < DB; i++) begin
            lane_mask[i] = (i >= lane_lo) && (i <= lane_hi);
        end
    end

endmodule

// File: rtl/axi_sram_wr_ctrl.sv
// AXI4 write-channel slave: accepts one AW burst at a time, issues one
// registered SRAM word write per W beat, then returns a B response.
module axi_sram_wr_ctrl
    import axi_func_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 12
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETn,
    input  logic [ID_WIDTH-1:0]                      awid,
    input  logic [ADDR_WIDTH-1:0]                    awaddr,
    input  logic [7:0]                               awlen,
    input  logic [2:0]                               awsize,
    input  logic [1:0]                               awburst,
    input  logic                                     awvalid,
    output logic                                     awready,
    input  logic [DATA_WIDTH-1:0]                    wdata,
    input  logic [DATA_WIDTH/8-1:0]                  wstrb,
    input  logic                                     wlast,
    input  logic                                     wvalid,
    output logic                                     wready,
    output logic [ID_WIDTH-1:0]                      bid,
    output logic [1:0]                               bresp,
    output logic                                     bvalid,
    input  logic                                     bready,
    output logic                                     mem_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]                    mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                  mem_be
);

    localparam int unsigned DB      = DATA_WIDTH / 8;
    localparam int unsigned DB_LOG2 = $clog2(DB);
    localparam int unsigned MEM_AW  = ADDR_WIDTH - DB_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic [ID_WIDTH-1:0]   id_q,        id_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [7:0]            len_q,       len_d;
    logic [2:0]            size_q,      size_d;
    burst_e                burst_q,     burst_d;
    logic [7:0]            beat_cnt_q,  beat_cnt_d;
    logic                  err_q,       err_d;
    logic                  awready_q,   awready_d;
    logic                  wready_q,    wready_d;
    logic                  bvalid_q,    bvalid_d;
    logic [1:0]            bresp_q,     bresp_d;
    logic [ID_WIDTH-1:0]   bid_q,       bid_d;
    logic                  mem_we_q,    mem_we_d;
    logic [MEM_AW-1:0]     mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DB-1:0]         mem_be_q,    mem_be_d;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [DB-1:0]         lane_mask;
    logic                  size_err;
    logic                  wrap_err;
    logic                  last_beat;

    axi_wr_lane_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane_calc (
        .cur_addr   (addr_q),
        .size       (size_q),
        .len        (len_q),
        .burst      (burst_q),
        .first_beat (beat_cnt_q == 8'd0),
        .next_addr  (next_addr),
        .lane_mask  (lane_mask)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        size_err  = 32'(awsize) > DB_LOG2;
        wrap_err  = (awburst == 2'd2) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
        last_beat = (beat_cnt_q == len_q);

        case (state_q)
            S_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    id_d       = awid;
                    addr_d     = awaddr;
                    len_d      = awlen;
                    size_d     = awsize;
                    burst_d    = (awburst == 2'd3) ? BURST_INCR : burst_e'(awburst);
                    beat_cnt_d = 8'd0;
                    err_d      = size_err || wrap_err;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    state_d    = S_DATA;
                end
            end

            S_DATA: begin
                if (wvalid && wready_q) begin
                    // The write uses the error flag as it stood before this beat.
                    mem_we_d    = !err_q;
                    mem_wdata_d = wdata;
                    mem_addr_d  = addr_q[ADDR_WIDTH-1:DB_LOG2];
                    mem_be_d    = lane_mask & wstrb;
                    addr_d      = next_addr;
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    if (wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = err_d ? SLVERR : OKAY;
                        state_d  = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (bvalid_q && bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            bid_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bresp     = bresp_q;
    assign bid       = bid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_axi_sram_wr_ctrl.sv
// Scoreboard bench for axi_sram_wr_ctrl: a byte-level burst model queues the
// expected SRAM writes and B responses, a negedge monitor pops and compares.
module tb_axi_sram_wr_ctrl;

    localparam int DB    = 4;
    localparam int LIMIT = 200;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [11:0] awid = '0;
    logic [15:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    always #5 ACLK = ~ACLK;

    axi_sram_wr_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .ID_WIDTH   (12)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    typedef struct {
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [11:0] id;
        logic [1:0]  resp;
    } b_t;

    wr_t exp_wr[$];
    b_t  exp_b[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"},   64'(awready),   64'd0);
        check({tag, "_wready"},    64'(wready),    64'd0);
        check({tag, "_bvalid"},    64'(bvalid),    64'd0);
        check({tag, "_bresp"},     64'(bresp),     64'd0);
        check({tag, "_bid"},       64'(bid),       64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_mem_be"},    64'(mem_be),    64'd0);
    endtask

    // Reference: each beat touches the bytes from its address up to the end of
    // its transfer (the NB-sized container on the first beat), clipped to the word.
    task automatic model_push(input logic [11:0] id, input int start, input int len,
                              input int size, input int burst, input int bad_beat,
                              input logic [31:0] data[16], input logic [3:0] strb[16],
                              input int n_beats, input bit push_b);
        int  bt, nb, al, region, base, a, word, last_byte;
        bit  err, wl;
        wr_t w;
        b_t  b;
        bt  = (burst == 3) ? 1 : burst;
        nb  = 1 << size;
        al  = (start / nb) * nb;
        err = (size > 2) || (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int n = 0; n < n_beats; n++) begin
            if (bt == 0 || n == 0) begin
                a = start;
            end else if (bt == 1) begin
                a = (al + n * nb) % 65536;
            end else begin
                region = nb * (len + 1);
                base   = (start / region) * region;
                a      = base + (al + n * nb - base) % region;
            end
            word      = a / DB;
            last_byte = (n == 0) ? al + nb - 1 : a + nb - 1;
            w.be = '0;
            for (int k = 0; k < DB; k++) begin
                if (word * DB + k >= a && word * DB + k <= last_byte) w.be[k] = 1'b1;
            end
            w.be   = w.be & strb[n];
            w.addr = 14'(word);
            w.data = data[n];
            wl = (n == len) != (n == bad_beat);
            if (!err) exp_wr.push_back(w);
            if (wl != (n == len)) err = 1'b1;
        end
        if (push_b) begin
            b.id   = id;
            b.resp = err ? 2'b10 : 2'b00;
            exp_b.push_back(b);
        end
    endtask

    task automatic aw_phase(input logic [11:0] id, input logic [15:0] addr, input int len,
                            input int size, input int burst);
        int cnt;
        awid    = id;
        awaddr  = addr;
        awlen   = 8'(len);
        awsize  = 3'(size);
        awburst = 2'(burst);
        awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < LIMIT) begin
            tick();
            cnt++;
        end
        check("aw_timeout", 64'(cnt >= LIMIT), 64'd0);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input int len, input int bad_beat, input logic [31:0] data[16],
                           input logic [3:0] strb[16], input int n_beats, input bit gaps);
        int cnt;
        for (int n = 0; n < n_beats; n++) begin
            if (gaps) begin
                wvalid = 1'b0;
                repeat ($urandom % 3) tick();
            end
            wvalid = 1'b1;
            wdata  = data[n];
            wstrb  = strb[n];
            wlast  = (n == len) != (n == bad_beat);
            cnt = 0;
            while (!wready && cnt < LIMIT) begin
                tick();
                cnt++;
            end
            check("w_timeout", 64'(cnt >= LIMIT), 64'd0);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_phase(input int bdelay);
        int cnt;
        bready = 1'b0;
        repeat (bdelay) tick();
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < LIMIT) begin
            tick();
            cnt++;
        end
        check("b_timeout", 64'(cnt >= LIMIT), 64'd0);
        tick();
        bready = 1'b0;
    endtask

    task automatic gen_beats(output logic [31:0] data[16], output logic [3:0] strb[16],
                             input bit full_strb);
        for (int n = 0; n < 16; n++) begin
            data[n] = $urandom;
            strb[n] = (full_strb || ($urandom % 2 == 0)) ? 4'hF : 4'($urandom);
        end
    endtask

    task automatic run_txn(input logic [11:0] id, input logic [15:0] addr, input int len,
                           input int size, input int burst, input int bad_beat,
                           input int bdelay, input bit gaps, input bit full_strb);
        logic [31:0] data[16];
        logic [3:0]  strb[16];
        gen_beats(data, strb, full_strb);
        model_push(id, int'(addr), len, size, burst, bad_beat, data, strb, len + 1, 1'b1);
        aw_phase(id, addr, len, size, burst);
        w_phase(len, bad_beat, data, strb, len + 1, gaps);
        b_phase(bdelay);
    endtask

    // Monitor: compares every SRAM write and B handshake against the queues,
    // and checks B stays stable while bready is low.
    logic        b_pend = 1'b0;
    logic [11:0] pend_id = '0;
    logic [1:0]  pend_resp = '0;

    initial begin
        wr_t ew;
        b_t  eb;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                b_pend = 1'b0;
            end else begin
                if (b_pend) begin
                    check("bvalid_hold", 64'(bvalid), 64'd1);
                    check("bid_hold",    64'(bid),    64'(pend_id));
                    check("bresp_hold",  64'(bresp),  64'(pend_resp));
                end
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        check("mem_we_unexpected", 64'(mem_we), 64'd0);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("mem_addr",  64'(mem_addr),  64'(ew.addr));
                        check("mem_be",    64'(mem_be),    64'(ew.be));
                        check("mem_wdata", 64'(mem_wdata), 64'(ew.data));
                    end
                end
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        check("bvalid_unexpected", 64'(bvalid), 64'd0);
                    end else begin
                        eb = exp_b.pop_front();
                        check("bid",   64'(bid),   64'(eb.id));
                        check("bresp", 64'(bresp), 64'(eb.resp));
                    end
                end
                b_pend    = bvalid && !bready;
                pend_id   = bid;
                pend_resp = bresp;
            end
        end
    end

    initial begin
        logic [31:0] data[16];
        logic [3:0]  strb[16];
        int burst, size, len, sel, bad;

        repeat (3) @(posedge ACLK);
        #1;
        check_outputs_zero("reset");
        ARESETn = 1'b1;
        check("awready_at_release", 64'(awready), 64'd0);
        tick();
        check("awready_after_release", 64'(awready), 64'd1);

        // W beats offered before any AW must not be taken.
        wvalid = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        wstrb  = 4'hF;
        wlast  = 1'b1;
        repeat (3) begin
            tick();
            check("wready_idle", 64'(wready), 64'd0);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;

        run_txn(12'h123, 16'h0010, 3, 2, 1, -1, 0, 1'b0, 1'b1);
        run_txn(12'h045, 16'h0013, 1, 2, 1, -1, 1, 1'b0, 1'b1);
        run_txn(12'h7A5, 16'h0038, 3, 2, 2, -1, 0, 1'b0, 1'b1);
        run_txn(12'h001, 16'h0002, 3, 0, 1, -1, 0, 1'b0, 1'b1);
        run_txn(12'h002, 16'h0020, 2, 1, 0, -1, 0, 1'b0, 1'b1);
        run_txn(12'h0F0, 16'h0040, 3, 3, 1, -1, 0, 1'b0, 1'b1);
        run_txn(12'h0F1, 16'h0040, 2, 2, 2, -1, 0, 1'b0, 1'b1);
        run_txn(12'h0F2, 16'h0080, 3, 2, 1,  1, 0, 1'b0, 1'b1);
        run_txn(12'hABC, 16'h0090, 1, 2, 1, -1, 5, 1'b0, 1'b1);
        run_txn(12'hFFF, 16'hFFF8, 3, 2, 3, -1, 2, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            burst = int'($urandom % 4);
            size  = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
            if (burst == 2) begin
                sel = int'($urandom % 5);
                len = (sel == 4) ? 2 : (2 << sel) - 1;
            end else begin
                len = int'($urandom % 8);
            end
            bad = ($urandom % 8 == 0) ? int'($urandom % (len + 1)) : -1;
            run_txn(12'($urandom), 16'($urandom), len, size, burst, bad,
                    int'($urandom % 4), 1'b1, 1'b0);
        end

        // Reset during beat 2 of an 8-beat burst: only the first two writes land.
        gen_beats(data, strb, 1'b1);
        model_push(12'h3C3, 32'h0100, 7, 2, 1, -1, data, strb, 2, 1'b0);
        aw_phase(12'h3C3, 16'h0100, 7, 2, 1);
        w_phase(7, -1, data, strb, 2, 1'b0);
        @(negedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        tick();
        tick();
        check("rst_mid_no_bvalid", 64'(bvalid), 64'd0);
        ARESETn = 1'b1;
        tick();
        check("awready_after_rst_mid", 64'(awready), 64'd1);
        run_txn(12'h5A5, 16'h0200, 3, 2, 1, -1, 1, 1'b1, 1'b0);

        repeat (5) tick();
        check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
        check("exp_b_drained",  64'(exp_b.size()),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_wr_ctrl.md
Name: axi_sram_wr_ctrl

Overview:
AXI4 write-channel slave front-end for the SRAM model. It accepts one AW transaction at a time and walks the W beats. For each beat it computes the address and active byte lanes using the package alignment, byte-lane and wrap-boundary rules. It issues a registered SRAM word write with byte enables, then returns a B response.

Parameters:
DATA_WIDTH, 32, W data width in bits (power of 2, >= 8).
ADDR_WIDTH, 16, byte address width.
ID_WIDTH, 12, AXI ID width.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESETn  in  1  asynchronous active-low reset.
awid  in  ID_WIDTH  write ID.
awaddr  in  ADDR_WIDTH  start byte address.
awlen  in  8  beats-1.
awsize  in  3  log2 bytes per beat.
awburst  in  2  0=FIXED, 1=INCR, 2=WRAP.
awvalid  in  1  AW valid.
awready  out  1  AW ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  write strobes.
wlast  in  1  last beat marker.
wvalid  in  1  W valid.
wready  out  1  W ready.
bid  out  ID_WIDTH  echoed awid.
bresp  out  2  OKAY=2'b00, SLVERR=2'b10.
bvalid  out  1  B valid.
bready  in  1  B ready.
mem_we  out  1  one-cycle SRAM write pulse.
mem_addr  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address.
mem_wdata  out  DATA_WIDTH  registered wdata.
mem_be  out  DATA_WIDTH/8  byte enables.

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, bid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. FSM goes to IDLE.
- Reset asserted mid-burst: the burst is abandoned, nothing is written, and no B response is issued.
- FSM states: IDLE -> DATA -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - awready=1, starting the first cycle after reset release.
  - On awvalid&&awready: latch id/addr/len/size/burst, clear beat count, go to DATA. awready drops the next cycle.
- Error flag is set at AW accept when either holds:
  - awsize > log2(DATA_WIDTH/8);
  - WRAP burst with awlen not in {1,3,7,15}.
  - awburst=3 is treated as INCR.
- DATA:
  - wready=1. Each wvalid&&wready is one beat.
  - One cycle later: mem_we=1 unless the error flag is set; mem_wdata=wdata; mem_addr=cur_addr>>log2(DATA_WIDTH/8).
- Byte lanes (NB=1<<awsize, DB=DATA_WIDTH/8):
  - First beat: lower = addr - (addr/DB)*DB; upper = aligned(addr,NB)+NB-1 - (addr/DB)*DB.
  - Later beats: lower = addr mod DB; upper = lower+NB-1.
  - mem_be = lane mask[lower..upper] & wstrb.
- Next address:
  - FIXED: unchanged.
  - INCR: aligned(addr,NB)+NB, modulo 2^ADDR_WIDTH.
  - WRAP: aligned+NB; if the result equals the upper wrap boundary (lower + NB*(len+1)), load the lower wrap boundary.
- Termination:
  - The beat counter is authoritative: after beat awlen+1, go to RESP and drop wready.
  - wlast asserted on a non-final beat, or absent on the final beat, sets the error flag. The write of that beat still occurs if the flag was clear before it.
  - wvalid gaps are allowed: no beat is counted and no mem_we is issued.
- RESP:
  - bvalid=1, bid=latched id, bresp = error ? SLVERR : OKAY.
  - Held stable until bready. On handshake, go to IDLE; awready=1 the next cycle.
- Throughput: no AW overlap. Minimum transaction length is (len+1) + 2 cycles plus B wait.
- W beats presented before AW is accepted are not taken (wready=0 in IDLE).

Decomposition:
- Package axi_func_pkg adds:
  - burst enum (FIXED/INCR/WRAP);
  - resp constants OKAY/SLVERR;
  - STROBE_WIDTH;
  - the existing aligned_address, byte-lane and wrap-boundary functions, reused unchanged.
- One combinational sub-module, axi_wr_lane_calc:
  - inputs: cur_addr, size, len, burst, first_beat;
  - outputs: next_addr, lane_mask.
- The FSM, counters and registers stay in axi_sram_wr_ctrl.

Test Plan:
1. INCR aligned: awaddr=0x0010, size=2, len=3, wstrb=0xF -> mem_addr 4,5,6,7, mem_be=0xF each, bresp=OKAY, bid=awid.
2. INCR unaligned: awaddr=0x0013, size=2, len=1, wstrb=0xF -> beat0 mem_addr 4 be 0x8; beat1 mem_addr 5 be 0xF; OKAY.
3. WRAP: awaddr=0x0038, size=2, len=3 -> byte addrs 0x38,0x3C,0x30,0x34 -> mem_addr 0xE,0xF,0xC,0xD; OKAY.
4. Narrow INCR: awaddr=0x0002, size=0, len=3, wstrb=0xF -> be 0x4,0x8,0x1,0x2; mem_addr 0,0,1,1. FIXED variant awaddr=0x20, size=1, len=2 -> mem_addr 8, be 0x3 x3.
5. Errors: size=3 len=3 -> 4 beats accepted, no mem_we, bresp=2'b10. WRAP len=2 -> SLVERR. wlast on beat 1 of len=3 -> SLVERR after 4 beats. bready low 5 cycles -> bvalid/bid/bresp held stable.
6. Reset mid-burst: drop ARESETn after beat 2 of len=7 -> all outputs 0 immediately, no bvalid. awready=1 one cycle after release; a new INCR burst completes correctly.
